// File: rtl/sram_cache.sv
// Two-way set-associative write-through, no-write-allocate cache in front of the SRAM controller.
// Optional hit/miss counters are enabled by defining CACHE_STATS_EN.
module sram_cache (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        sram_wr_en,
  output logic        sram_rd_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  typedef enum logic [1:0] {IDLE, READ_MISS, WRITE} state_t;

  state_t      state_q;
  logic [63:0] valid0_q, valid1_q, lru_q;
  logic [10:0] tag0_q  [64];
  logic [10:0] tag1_q  [64];
  logic [31:0] data0_q [64];
  logic [31:0] data1_q [64];

  logic [5:0]  idx;
  logic [10:0] tag;
  logic        hit0, hit1, hit;
  logic        victim;
  logic        fill_en, wr_upd;

  assign idx     = address[7:2];
  assign tag     = address[18:8];
  assign hit0    = valid0_q[idx] && (tag0_q[idx] == tag);
  assign hit1    = valid1_q[idx] && (tag1_q[idx] == tag);
  assign hit     = hit0 || hit1;
  assign victim  = lru_q[idx];
  assign fill_en = (state_q == READ_MISS) && sram_ready;
  assign wr_upd  = (state_q == WRITE) && sram_ready && hit;

  assign sram_address = address;
  assign sram_wdata   = wdata;

  always_comb begin
    ready = 1'b1;
    rdata = 32'h0;
    case (state_q)
      IDLE: begin
        if (mem_w_en) begin
          ready = 1'b0;
        end else if (mem_r_en) begin
          if (hit) rdata = hit0 ? data0_q[idx] : data1_q[idx];
          else     ready = 1'b0;
        end
      end
      READ_MISS: begin
        ready = sram_ready;
        rdata = sram_rdata;
      end
      WRITE:   ready = sram_ready;
      default: ready = 1'b1;
    endcase
  end

  // Request strobes are registered alongside the state so they follow it exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sram_rd_en <= 1'b0;
      sram_wr_en <= 1'b0;
      valid0_q   <= '0;
      valid1_q   <= '0;
      lru_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_w_en) begin
            state_q    <= WRITE;
            sram_wr_en <= 1'b1;
          end else if (mem_r_en) begin
            if (hit) begin
              lru_q[idx] <= hit0;
            end else begin
              state_q    <= READ_MISS;
              sram_rd_en <= 1'b1;
            end
          end
        end
        READ_MISS: begin
          if (sram_ready) begin
            if (!victim) valid0_q[idx] <= 1'b1;
            else         valid1_q[idx] <= 1'b1;
            lru_q[idx] <= ~victim;
            state_q    <= IDLE;
            sram_rd_en <= 1'b0;
          end
        end
        WRITE: begin
          if (sram_ready) begin
            if (hit) lru_q[idx] <= hit0;
            state_q    <= IDLE;
            sram_wr_en <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          sram_rd_en <= 1'b0;
          sram_wr_en <= 1'b0;
        end
      endcase
    end
  end

  // Tag/data need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      if (!victim) begin
        tag0_q[idx]  <= tag;
        data0_q[idx] <= sram_rdata;
      end else begin
        tag1_q[idx]  <= tag;
        data1_q[idx] <= sram_rdata;
      end
    end else if (wr_upd) begin
      if (hit0) data0_q[idx] <= wdata;
      else      data1_q[idx] <= wdata;
    end
  end

`ifdef CACHE_STATS_EN
  logic [15:0] hit_count_q, miss_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_q  <= 16'h0;
      miss_count_q <= 16'h0;
    end else begin
      if ((state_q == IDLE) && !mem_w_en && mem_r_en && hit && (hit_count_q != 16'hFFFF))
        hit_count_q <= hit_count_q + 16'd1;
      if (fill_en && (miss_count_q != 16'hFFFF))
        miss_count_q <= miss_count_q + 16'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_sram_cache.sv
// Directed bench for sram_cache with a behavioural SRAM controller (6-cycle read, 3-cycle write).
module tb_sram_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en, mem_w_en;
  logic [31:0] address, wdata, rdata;
  logic        ready;
  logic        sram_wr_en, sram_rd_en;
  logic [31:0] sram_address, sram_wdata, sram_rdata;
  logic        sram_ready;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  int total = 0;
  int bad   = 0;

  sram_cache dut (
    .clk(clk), .rst(rst),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
    .sram_wr_en(sram_wr_en), .sram_rd_en(sram_rd_en),
    .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  // Controller model: ready while idle and in the last busy cycle.
  logic [31:0] mem [0:1023];
  bit          mem_init;
  int          cnt;

  assign sram_ready = sram_rd_en ? (cnt == 5) : sram_wr_en ? (cnt == 2) : 1'b1;
  assign sram_rdata = sram_rd_en ? mem[sram_address[11:2]] : 32'h0;

  always @(posedge clk) begin
    if (rst) begin
      cnt <= 0;
      if (!mem_init) begin
        for (int i = 0; i < 1024; i++) mem[i] <= 32'hA500_0000 | i;
        mem[10'h040] <= 32'h1234_5678;
        mem_init <= 1'b1;
      end
    end else begin
      if ((sram_rd_en || sram_wr_en) && !sram_ready) cnt <= cnt + 1;
      else cnt <= 0;
      if (sram_wr_en && sram_ready) mem[sram_address[11:2]] <= sram_wdata;
    end
  end

  // Issues one request and returns the cycle count up to and including the ready cycle.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        output int cyc, output logic [31:0] rd,
                        output int n_rd, output int n_wr, output int n_both);
    mem_w_en = we; mem_r_en = !we; address = addr; wdata = wd;
    cyc = 0; rd = 32'h0; n_rd = 0; n_wr = 0; n_both = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sram_rd_en) n_rd++;
      if (sram_wr_en) n_wr++;
      if (sram_rd_en && sram_wr_en) n_both++;
      if (ready) begin
        cyc = i + 1;
        rd  = rdata;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    mem_r_en = 1'b0; mem_w_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; address = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (ready !== 1'b1)      begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
    total++; if (rdata !== 32'h0)     begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    total++; if (sram_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b exp=0", sram_rd_en); end
    total++; if (sram_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b exp=0", sram_wr_en); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_read_miss();
    int c, nr, nw, nb; logic [31:0] d;
    do_req(1'b0, 32'h0000_0100, 32'h0, c, d, nr, nw, nb);
    total++; if (c !== 7)             begin bad++; $display("FAIL miss_cycles got=%0d exp=7", c); end
    total++; if (d !== 32'h1234_5678) begin bad++; $display("FAIL miss_rdata got=%h exp=12345678", d); end
    total++; if (nr !== 6)            begin bad++; $display("FAIL miss_rd_en_cycles got=%0d exp=6", nr); end
    total++; if (nb !== 0)            begin bad++; $display("FAIL miss_both_en got=%0d exp=0", nb); end
    do_req(1'b0, 32'h0000_0100, 32'h0, c, d, nr, nw, nb);
    total++; if (c !== 1)             begin bad++; $display("FAIL hit_cycles got=%0d exp=1", c); end
    total++; if (d !== 32'h1234_5678) begin bad++; $display("FAIL hit_rdata got=%h exp=12345678", d); end
    total++; if (nr !== 0)            begin bad++; $display("FAIL hit_rd_en got=%0d exp=0", nr); end
  endtask

  task automatic test_lru_evict();
    int c, nr, nw, nb; logic [31:0] d;
    do_req(1'b0, 32'h0000_0200, 32'h0, c, d, nr, nw, nb);
    total++; if (c !== 7)             begin bad++; $display("FAIL fill200_cycles got=%0d exp=7", c); end
    total++; if (d !== 32'hA500_0080) begin bad++; $display("FAIL fill200_rdata got=%h exp=a5000080", d); end
    do_req(1'b0, 32'h0000_0100, 32'h0, c, d, nr, nw, nb);
    total++; if (c !== 1)             begin bad++; $display("FAIL rehit100_cycles got=%0d exp=1", c); end
    do_req(1'b0, 32'h0000_0300, 32'h0, c, d, nr, nw, nb);
    total++; if (c !== 7)             begin bad++; $display("FAIL fill300_cycles got=%0d exp=7", c); end
    total++; if (d !== 32'hA500_00C0) begin bad++; $display("FAIL fill300_rdata got=%h exp=a50000c0", d); end
    do_req(1'b0, 32'h0000_0100, 32'h0, c, d, nr, nw, nb);
    total++; if (c !== 1)             begin bad++; $display("FAIL keep100_cycles got=%0d exp=1", c); end
    total++; if (d !== 32'h1234_5678) begin bad++; $display("FAIL keep100_rdata got=%h exp=12345678", d); end
    do_req(1'b0, 32'h0000_0200, 32'h0, c, d, nr, nw, nb);
    total++; if (c !== 7)             begin bad++; $display("FAIL evicted200_cycles got=%0d exp=7", c); end
  endtask

  task automatic test_write_hit();
    int c, nr, nw, nb; logic [31:0] d;
    do_req(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, c, d, nr, nw, nb);
    total++; if (c !== 4)             begin bad++; $display("FAIL wr_hit_cycles got=%0d exp=4", c); end
    total++; if (nw !== 3)            begin bad++; $display("FAIL wr_hit_wr_en got=%0d exp=3", nw); end
    total++; if (nr !== 0)            begin bad++; $display("FAIL wr_hit_rd_en got=%0d exp=0", nr); end
    do_req(1'b0, 32'h0000_0100, 32'h0, c, d, nr, nw, nb);
    total++; if (c !== 1)             begin bad++; $display("FAIL wr_hit_read_cycles got=%0d exp=1", c); end
    total++; if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_hit_read_rdata got=%h exp=deadbeef", d); end
  endtask

  task automatic test_write_miss();
    int c, nr, nw, nb; logic [31:0] d;
    do_req(1'b1, 32'h0000_0400, 32'hCAFE_0001, c, d, nr, nw, nb);
    total++; if (c !== 4)             begin bad++; $display("FAIL wr_miss_cycles got=%0d exp=4", c); end
    do_req(1'b0, 32'h0000_0400, 32'h0, c, d, nr, nw, nb);
    total++; if (c !== 7)             begin bad++; $display("FAIL wr_noalloc_cycles got=%0d exp=7", c); end
    total++; if (d !== 32'hCAFE_0001) begin bad++; $display("FAIL wr_noalloc_rdata got=%h exp=cafe0001", d); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    total++; if (ready !== 1'b1 || rdata !== 32'h0) begin bad++; $display("FAIL idle got=%b/%h exp=1/0", ready, rdata); end
    @(posedge clk); #1;
    mem_r_en = 1'b1; address = 32'h0000_0400;
    @(negedge clk);
    total++; if (ready !== 1'b1 || rdata !== 32'hCAFE_0001) begin bad++; $display("FAIL b2b_first got=%b/%h exp=1/cafe0001", ready, rdata); end
    @(posedge clk); #1 address = 32'h0000_0100;
    @(negedge clk);
    total++; if (ready !== 1'b1 || rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL b2b_second got=%b/%h exp=1/deadbeef", ready, rdata); end
    @(posedge clk); #1 mem_r_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int c, nr, nw, nb; logic [31:0] d;
    mem_r_en = 1'b1; address = 32'h0000_0200;
    repeat (3) @(posedge clk);
    #2;
    total++; if (sram_rd_en !== 1'b1) begin bad++; $display("FAIL mid_pre_rd_en got=%b exp=1", sram_rd_en); end
    rst = 1'b1; mem_r_en = 1'b0;
    #1;
    total++; if (sram_rd_en !== 1'b0) begin bad++; $display("FAIL mid_rst_rd_en got=%b exp=0", sram_rd_en); end
    total++; if (ready !== 1'b1)      begin bad++; $display("FAIL mid_rst_ready got=%b exp=1", ready); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    do_req(1'b0, 32'h0000_0100, 32'h0, c, d, nr, nw, nb);
    total++; if (c !== 7)             begin bad++; $display("FAIL post_rst_cycles got=%0d exp=7", c); end
    total++; if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL post_rst_rdata got=%h exp=deadbeef", d); end
    do_req(1'b0, 32'h0000_0400, 32'h0, c, d, nr, nw, nb);
    total++; if (c !== 7)             begin bad++; $display("FAIL post_rst_400_cycles got=%0d exp=7", c); end
  endtask

`ifdef CACHE_STATS_EN
  task automatic test_stats();
    int c, nr, nw, nb; logic [31:0] d;
    for (int k = 0; k < 3; k++) do_req(1'b0, 32'h0000_0100, 32'h0, c, d, nr, nw, nb);
    total++; if (hit_count !== 16'd3)  begin bad++; $display("FAIL stats_hits got=%0d exp=3", hit_count); end
    total++; if (miss_count !== 16'd2) begin bad++; $display("FAIL stats_misses got=%0d exp=2", miss_count); end
    mem_r_en = 1'b1; address = 32'h0000_0100;
    repeat (65536) @(posedge clk);
    #1 mem_r_en = 1'b0;
    total++; if (hit_count !== 16'hFFFF) begin bad++; $display("FAIL stats_sat got=%h exp=ffff", hit_count); end
    total++; if (miss_count !== 16'd2)   begin bad++; $display("FAIL stats_sat_miss got=%0d exp=2", miss_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_read_miss();
    test_lru_evict();
    test_write_hit();
    test_write_miss();
    test_back_to_back();
    test_reset_mid();
`ifdef CACHE_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
